// File: rtl/wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// wash_cycle_sequencer
//
// Sequences a washing-machine program. The program has NUM_PHASES timed phases.
// Flow: IDLE -> ARM (ARM_TICKS minute ticks) -> RUN (phases counted down per
// tick) -> DONE (one-cycle pulse) -> IDLE.
//
// At program start, the phase times and the operator selections are captured
// into shadow registers. Later edits therefore cannot disturb a running
// program. A program can be paused by start_op, by the door opening, or by the
// door level reading open. Holding start for HOLD_CYCLES consecutive cycles
// aborts the program from any active state.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-low reset
//   start_op         one-cycle start/pause pulse
//   start_hold       debounced start level (long press aborts)
//   door_open_op     one-cycle door-opened pulse
//   door_closed      door level, 1 = closed
//   reserve_done_op  one-cycle reservation-expired pulse (starts like start_op)
//   tick             one-cycle minute enable
//   phase_time       minutes for phase k at [k*TIME_W +: TIME_W]
//   water_sel        operator water selection
//   temp_sel         operator temperature selection
//   state            FSM state (IDLE=0 ARM=1 RUN=2 PAUSE=3 DONE=4)
//   phase_idx        current phase index
//   remaining        minutes left in the current phase
//   water_out        water selection latched at program start
//   temp_out         temperature selection latched at program start
//   busy             1 whenever state != IDLE (combinational)
//   done_op          one-cycle completion pulse, coincident with DONE
// -----------------------------------------------------------------------------
module wash_cycle_sequencer #(
   parameter int NUM_PHASES  = 4,
   parameter int TIME_W      = 8,
   parameter int HOLD_CYCLES = 50,
   parameter int ARM_TICKS   = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_op,
   input  logic                             start_hold,
   input  logic                             door_open_op,
   input  logic                             door_closed,
   input  logic                             reserve_done_op,
   input  logic                             tick,
   input  logic [NUM_PHASES*TIME_W-1:0]     phase_time,
   input  logic [2:0]                       water_sel,
   input  logic [2:0]                       temp_sel,
   output logic [2:0]                       state,
   output logic [$clog2(NUM_PHASES)-1:0]    phase_idx,
   output logic [TIME_W-1:0]                remaining,
   output logic [2:0]                       water_out,
   output logic [2:0]                       temp_out,
   output logic                             busy,
   output logic                             done_op
);

   localparam int IDX_W  = $clog2(NUM_PHASES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int ARM_W  = (ARM_TICKS > 1) ? $clog2(ARM_TICKS) : 1;

   localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                cur_state, nxt_state;
   logic [TIME_W-1:0]     shadow_time [NUM_PHASES];
   logic [ARM_W-1:0]      arm_cnt, nxt_arm_cnt;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [IDX_W-1:0]      nxt_phase;
   logic [TIME_W-1:0]     nxt_remaining;
   logic                  latch_sel;
   logic                  abort;
   logic                  pause_req;
   logic                  first_found, next_found;
   logic [IDX_W-1:0]      first_idx, next_idx;

   assign state     = cur_state;
   assign busy      = (cur_state != S_IDLE);
   assign pause_req = start_op | door_open_op | ~door_closed;

   // The abort fires on the HOLD_CYCLES-th consecutive held cycle, so the
   // state is already IDLE on the cycle after that one.
   assign abort = (cur_state != S_IDLE) && start_hold && (hold_cnt >= HOLD_LAST);

   // Phase search over the shadow times. first_* is the lowest nonzero phase
   // (used when leaving ARM). next_* is the lowest nonzero phase above
   // phase_idx, so zero-time phases are skipped within one cycle. The loop
   // walks downward, so the last hit, which is the lowest index, wins.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int k = NUM_PHASES - 1; k >= 0; k--) begin
         if (shadow_time[k] != '0) begin
            first_found = 1'b1;
            first_idx   = IDX_W'(k);
            if (k > int'(phase_idx)) begin
               next_found = 1'b1;
               next_idx   = IDX_W'(k);
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         cur_state <= nxt_state;
      end
   end

   // Next state and datapath next values. Priority within a cycle is:
   // abort, then door/pause condition, then start_op, then tick.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches.
      nxt_state     = cur_state;
      nxt_phase     = phase_idx;
      nxt_remaining = remaining;
      nxt_arm_cnt   = arm_cnt;
      latch_sel     = 1'b0;

      case (cur_state)
         S_IDLE: begin
            if ((start_op || reserve_done_op) && door_closed) begin
               nxt_state   = S_ARM;
               nxt_arm_cnt = '0;
               latch_sel   = 1'b1;
            end
         end

         S_ARM: begin
            if (!door_closed) begin
               nxt_state = S_IDLE;
            end else if (tick) begin
               if (arm_cnt == ARM_LAST) begin
                  nxt_arm_cnt = '0;
                  if (first_found) begin
                     nxt_state     = S_RUN;
                     nxt_phase     = first_idx;
                     nxt_remaining = shadow_time[first_idx];
                  end else begin
                     nxt_state = S_DONE;
                  end
               end else begin
                  nxt_arm_cnt = arm_cnt + 1'b1;
               end
            end
         end

         S_RUN: begin
            if (pause_req) begin
               // A coincident tick is dropped; phase and time stay frozen.
               nxt_state = S_PAUSE;
            end else if (tick) begin
               if (remaining > TIME_W'(1)) begin
                  nxt_remaining = remaining - 1'b1;
               end else if (next_found) begin
                  nxt_phase     = next_idx;
                  nxt_remaining = shadow_time[next_idx];
               end else begin
                  nxt_state     = S_DONE;
                  nxt_remaining = '0;
               end
            end
         end

         S_PAUSE: begin
            if (start_op && door_closed) begin
               nxt_state = S_RUN;
            end
         end

         S_DONE: nxt_state = S_IDLE;

         default: nxt_state = S_IDLE;
      endcase

      if (abort) begin
         nxt_state = S_IDLE;
         latch_sel = 1'b0;
      end

      if (nxt_state == S_IDLE) begin
         nxt_phase     = '0;
         nxt_remaining = '0;
         nxt_arm_cnt   = '0;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_idx <= '0;
         remaining <= '0;
         arm_cnt   <= '0;
         hold_cnt  <= '0;
         done_op   <= 1'b0;
         water_out <= '0;
         temp_out  <= '0;
         // NOTE: the shadow array is reset because it must read zero after reset.
         for (int k = 0; k < NUM_PHASES; k++) begin
            shadow_time[k] <= '0;
         end
      end else begin
         phase_idx <= nxt_phase;
         remaining <= nxt_remaining;
         arm_cnt   <= nxt_arm_cnt;
         done_op   <= (nxt_state == S_DONE);

         if ((cur_state == S_IDLE) || !start_hold) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         if (latch_sel) begin
            water_out <= water_sel;
            temp_out  <= temp_sel;
            for (int k = 0; k < NUM_PHASES; k++) begin
               shadow_time[k] <= phase_time[k*TIME_W +: TIME_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_sequencer
//
// Directed bench for wash_cycle_sequencer with its default parameters
// (4 phases, 8-bit times, abort after 50 held cycles, 3 arm ticks).
//
// Before each clock edge, the stimulus code pushes the state and counters it
// expects after that edge. After the edge, the scoreboard pops each entry and
// compares it against the outputs.
// -----------------------------------------------------------------------------
module tb_wash_cycle_sequencer;

   localparam int NP = 4;
   localparam int TW = 8;
   // ph0=2, ph1=0, ph2=1, ph3=3
   localparam logic [NP*TW-1:0] PT_A = 32'h03_01_00_02;

   logic            clk;
   logic            reset;
   logic            start_op;
   logic            start_hold;
   logic            door_open_op;
   logic            door_closed;
   logic            reserve_done_op;
   logic            tick;
   logic [NP*TW-1:0] phase_time;
   logic [2:0]      water_sel;
   logic [2:0]      temp_sel;
   logic [2:0]      state;
   logic [1:0]      phase_idx;
   logic [TW-1:0]   remaining;
   logic [2:0]      water_out;
   logic [2:0]      temp_out;
   logic            busy;
   logic            done_op;

   int n_cmp;
   int n_err;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [1:0] ph;
      logic [7:0] rem;
      logic       dn;
      logic       care;   // 0: phase/remaining are don't-care
   } exp_t;

   exp_t sb[$];

   wash_cycle_sequencer #(
      .NUM_PHASES (NP),
      .TIME_W     (TW),
      .HOLD_CYCLES(50),
      .ARM_TICKS  (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start_op       (start_op),
      .start_hold     (start_hold),
      .door_open_op   (door_open_op),
      .door_closed    (door_closed),
      .reserve_done_op(reserve_done_op),
      .tick           (tick),
      .phase_time     (phase_time),
      .water_sel      (water_sel),
      .temp_sel       (temp_sel),
      .state          (state),
      .phase_idx      (phase_idx),
      .remaining      (remaining),
      .water_out      (water_out),
      .temp_out       (temp_out),
      .busy           (busy),
      .done_op        (done_op)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Push the expectation for the next edge, advance one clock, then drain.
   task automatic step(input string tag, input logic [2:0] st, input logic [1:0] ph,
                       input logic [7:0] rem, input logic dn, input logic care = 1'b1);
      exp_t e;
      e.tag  = tag;
      e.st   = st;
      e.ph   = ph;
      e.rem  = rem;
      e.dn   = dn;
      e.care = care;
      sb.push_back(e);
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".state"}, state, e.st);
         check({e.tag, ".busy"}, busy, e.st != 3'd0);
         check({e.tag, ".done"}, done_op, e.dn);
         if (e.care) begin
            check({e.tag, ".phase"}, phase_idx, e.ph);
            check({e.tag, ".rem"}, remaining, e.rem);
         end
      end
   endtask

   task automatic do_tick(input string tag, input logic [2:0] st, input logic [1:0] ph,
                          input logic [7:0] rem, input logic dn, input logic care = 1'b1);
      tick = 1'b1;
      step(tag, st, ph, rem, dn, care);
      tick = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".state"}, state, 0);
      check({tag, ".phase"}, phase_idx, 0);
      check({tag, ".rem"}, remaining, 0);
      check({tag, ".water"}, water_out, 0);
      check({tag, ".temp"}, temp_out, 0);
      check({tag, ".done"}, done_op, 0);
      check({tag, ".busy"}, busy, 0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      start_op = 1'b0;
      start_hold = 1'b0;
      door_open_op = 1'b0;
      door_closed = 1'b1;
      reserve_done_op = 1'b0;
      tick = 1'b0;
      phase_time = PT_A;
      water_sel = 3'd5;
      temp_sel = 3'd3;

      #2 reset = 1'b0;
      #1 check_all_zero("por");
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      step("idle", 3'd0, 2'd0, 8'd0, 1'b0);

      // Normal program: ph1 skipped, DONE after 9 ticks, inputs changed mid-run
      start_op = 1'b1;
      step("a_start", 3'd1, 2'd0, 8'd0, 1'b0);
      start_op = 1'b0;
      phase_time = '1;
      water_sel = 3'd1;
      temp_sel = 3'd6;
      check("a_water", water_out, 5);
      check("a_temp", temp_out, 3);
      do_tick("a_arm1", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("a_arm2", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("a_run0", 3'd2, 2'd0, 8'd2, 1'b0);
      step("a_notick", 3'd2, 2'd0, 8'd2, 1'b0);
      do_tick("a_t4", 3'd2, 2'd0, 8'd1, 1'b0);
      do_tick("a_skip", 3'd2, 2'd2, 8'd1, 1'b0);
      do_tick("a_ph3", 3'd2, 2'd3, 8'd3, 1'b0);
      do_tick("a_t7", 3'd2, 2'd3, 8'd2, 1'b0);
      do_tick("a_t8", 3'd2, 2'd3, 8'd1, 1'b0);
      do_tick("a_done", 3'd4, 2'd0, 8'd0, 1'b1, 1'b0);
      step("a_idle", 3'd0, 2'd0, 8'd0, 1'b0);
      step("a_idle2", 3'd0, 2'd0, 8'd0, 1'b0);
      check("a_water_hold", water_out, 5);
      check("a_temp_hold", temp_out, 3);

      // Pause/resume behaviour
      phase_time = PT_A;
      start_op = 1'b1;
      step("b_start", 3'd1, 2'd0, 8'd0, 1'b0);
      start_op = 1'b0;
      check("b_water", water_out, 1);
      do_tick("b_arm1", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("b_arm2", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("b_run0", 3'd2, 2'd0, 8'd2, 1'b0);
      tick = 1'b1;
      door_open_op = 1'b1;
      step("b_pause", 3'd3, 2'd0, 8'd2, 1'b0);
      tick = 1'b0;
      door_open_op = 1'b0;
      door_closed = 1'b0;
      step("b_open", 3'd3, 2'd0, 8'd2, 1'b0);
      start_op = 1'b1;
      step("b_start_open", 3'd3, 2'd0, 8'd2, 1'b0);
      start_op = 1'b0;
      do_tick("b_tick_paused", 3'd3, 2'd0, 8'd2, 1'b0);
      door_closed = 1'b1;
      step("b_closed", 3'd3, 2'd0, 8'd2, 1'b0);
      start_op = 1'b1;
      step("b_resume", 3'd2, 2'd0, 8'd2, 1'b0);
      start_op = 1'b0;
      do_tick("b_t", 3'd2, 2'd0, 8'd1, 1'b0);
      start_op = 1'b1;
      step("b_pause2", 3'd3, 2'd0, 8'd1, 1'b0);
      step("b_resume2", 3'd2, 2'd0, 8'd1, 1'b0);
      start_op = 1'b0;
      door_closed = 1'b0;
      step("b_door_low", 3'd3, 2'd0, 8'd1, 1'b0);
      door_closed = 1'b1;
      start_op = 1'b1;
      step("b_resume3", 3'd2, 2'd0, 8'd1, 1'b0);
      start_op = 1'b0;
      do_tick("b_ph2", 3'd2, 2'd2, 8'd1, 1'b0);

      // Long press: 49 cycles is harmless, 50 aborts
      start_hold = 1'b1;
      for (int i = 0; i < 49; i++) step("h49", 3'd2, 2'd2, 8'd1, 1'b0);
      start_hold = 1'b0;
      step("h_release", 3'd2, 2'd2, 8'd1, 1'b0);
      start_hold = 1'b1;
      for (int i = 0; i < 49; i++) step("h50", 3'd2, 2'd2, 8'd1, 1'b0);
      step("h_abort", 3'd0, 2'd0, 8'd0, 1'b0);
      start_hold = 1'b0;
      step("h_after", 3'd0, 2'd0, 8'd0, 1'b0);

      // All-zero program via reservation; door-open start ignored
      phase_time = '0;
      door_closed = 1'b0;
      reserve_done_op = 1'b1;
      step("c_ign", 3'd0, 2'd0, 8'd0, 1'b0);
      door_closed = 1'b1;
      step("c_arm", 3'd1, 2'd0, 8'd0, 1'b0, 1'b0);
      reserve_done_op = 1'b0;
      do_tick("c_t1", 3'd1, 2'd0, 8'd0, 1'b0, 1'b0);
      start_op = 1'b1;
      step("c_start_ign", 3'd1, 2'd0, 8'd0, 1'b0, 1'b0);
      start_op = 1'b0;
      do_tick("c_t2", 3'd1, 2'd0, 8'd0, 1'b0, 1'b0);
      do_tick("c_done", 3'd4, 2'd0, 8'd0, 1'b1, 1'b0);
      step("c_idle", 3'd0, 2'd0, 8'd0, 1'b0);

      // ARM cancel by door, then a fresh arm needs the full 3 ticks
      phase_time = PT_A;
      start_op = 1'b1;
      step("e_start", 3'd1, 2'd0, 8'd0, 1'b0);
      start_op = 1'b0;
      do_tick("e_t1", 3'd1, 2'd0, 8'd0, 1'b0);
      door_closed = 1'b0;
      tick = 1'b1;
      step("e_cancel", 3'd0, 2'd0, 8'd0, 1'b0);
      tick = 1'b0;
      door_closed = 1'b1;
      start_op = 1'b1;
      step("e_restart", 3'd1, 2'd0, 8'd0, 1'b0);
      start_op = 1'b0;
      do_tick("e_a1", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("e_a2", 3'd1, 2'd0, 8'd0, 1'b0);
      do_tick("e_run", 3'd2, 2'd0, 8'd2, 1'b0);
      do_tick("e_r1", 3'd2, 2'd0, 8'd1, 1'b0);
      do_tick("e_r2", 3'd2, 2'd2, 8'd1, 1'b0);
      do_tick("e_r3", 3'd2, 2'd3, 8'd3, 1'b0);
      do_tick("e_r4", 3'd2, 2'd3, 8'd2, 1'b0);

      // Asynchronous reset mid-program
      #2 reset = 1'b0;
      #1 check_all_zero("d_async");
      @(posedge clk);
      #1 reset = 1'b1;
      door_closed = 1'b0;
      start_op = 1'b1;
      step("d_ign", 3'd0, 2'd0, 8'd0, 1'b0);
      start_op = 1'b0;
      step("d_idle", 3'd0, 2'd0, 8'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
